result_capture: RTL and testbench

RESULT_CAPTURE -- requirements
Module: result_capture

---
 rtl/result_capture_pkg.sv | 20 ++
 rtl/result_fifo.sv | 47 ++++
 rtl/result_capture.sv | 122 ++++++++++++
 tb/tb_result_capture.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/result_capture_pkg.sv
// Shared types for the result capture block: capture record layout and timeout FSM states.
package result_capture_pkg;

    localparam int IDX_WIDTH = 8;
    localparam int AMBA_WORD = 32;

    typedef struct packed {
        logic [IDX_WIDTH-1:0] index;
        logic [1:0]           ctrl;
        logic [1:0]           num_err;
        logic [AMBA_WORD-1:0] data;
    } result_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_EXPIRED = 2'd2
    } tmo_state_e;

endpackage

// File: rtl/result_fifo.sv
// Synchronous show-ahead FIFO holding captured result records.
module result_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/result_capture.sv
// Captures encoder/decoder results on operation_done rising edges into a FIFO for the checker.
// Optional start-to-done watchdog is built only when RESULT_CAPTURE_TIMEOUT_EN is defined.
module result_capture
    import result_capture_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 operation_done_i,
    input  logic [1:0]           ctrl_i,
    input  logic [AMBA_WORD-1:0] data_out_i,
    input  logic [1:0]           num_of_errors_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [AMBA_WORD-1:0] res_data_o,
    output logic [1:0]           res_num_err_o,
    output logic [1:0]           res_ctrl_o,
    output logic [IDX_WIDTH-1:0] res_index_o,
    output logic                 overflow_o,
    output logic [7:0]           drop_cnt_o,
    output logic                 timeout_o
);

    logic                 done_q;
    logic [IDX_WIDTH-1:0] idx_q;
    logic [7:0]           drop_cnt_q;
    logic                 overflow_q;
    logic                 cap, pop, push, drop, full, empty;
    result_t              wr_entry, head;

    assign cap  = operation_done_i & ~done_q;
    assign pop  = ~empty & res_ready_i;
    assign push = cap & (~full | pop);
    assign drop = cap & full & ~pop;

    assign wr_entry = '{index: idx_q, ctrl: ctrl_i, num_err: num_of_errors_i, data: data_out_i};

    result_fifo #(.WIDTH($bits(result_t)), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // Storage is not reset, so the head is masked while nothing is queued.
    assign res_valid_o   = ~empty;
    assign res_data_o    = empty ? '0 : head.data;
    assign res_num_err_o = empty ? '0 : head.num_err;
    assign res_ctrl_o    = empty ? '0 : head.ctrl;
    assign res_index_o   = empty ? '0 : head.index;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q     <= 1'b0;
            idx_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= operation_done_i;
            if (cap) idx_q <= idx_q + 1'b1;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

`ifdef RESULT_CAPTURE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    tmo_state_e    state_q;
    logic [CW-1:0] cnt_q, cnt_inc;
    logic          timeout_q;

    assign cnt_inc   = cnt_q + 1'b1;
    assign timeout_o = timeout_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (start_i) begin
                        cnt_q <= '0;
                    end else if (cap) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                        state_q   <= ST_EXPIRED;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    if (start_i) begin
                        state_q   <= ST_WAIT;
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
                    end
                end
            endcase
        end
    end
`else
    logic unused_start;
    assign unused_start = start_i;
    assign timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_result_capture.sv
// Directed bench for result_capture: queue-based reference model plus literal spot checks.
// Timeout expectations follow RESULT_CAPTURE_TIMEOUT_EN.
module tb_result_capture;

    localparam int DEPTH   = 8;
    localparam int TMO     = 2;
`ifdef RESULT_CAPTURE_TIMEOUT_EN
    localparam bit TO_EN   = 1'b1;
`else
    localparam bit TO_EN   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, od = 1'b0, ready = 1'b0;
    logic [1:0]  ctrl = '0, nerr = '0;
    logic [31:0] data = '0;
    logic        res_valid, overflow, timeout;
    logic [31:0] res_data;
    logic [1:0]  res_num_err, res_ctrl;
    logic [7:0]  res_index, drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    result_capture #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .operation_done_i (od),
        .ctrl_i           (ctrl),
        .data_out_i       (data),
        .num_of_errors_i  (nerr),
        .res_valid_o      (res_valid),
        .res_ready_i      (ready),
        .res_data_o       (res_data),
        .res_num_err_o    (res_num_err),
        .res_ctrl_o       (res_ctrl),
        .res_index_o      (res_index),
        .overflow_o       (overflow),
        .drop_cnt_o       (drop_cnt),
        .timeout_o        (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: list of captured records, counters, and a start-to-done watchdog.
    typedef struct {
        logic [7:0]  idx;
        logic [1:0]  c;
        logic [1:0]  ne;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    int   m_idx, m_drop, m_elapsed;
    bit   m_ovf, m_prev, m_active, m_to;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_idx = 0; m_drop = 0; m_ovf = 0; m_prev = 0;
                m_active = 0; m_elapsed = 0; m_to = 0;
            end else begin
                automatic bit cap_e  = od && !m_prev;
                automatic bit pop_e  = (mq.size() > 0) && ready;
                automatic bit was_full = (mq.size() == DEPTH);
                if (pop_e) void'(mq.pop_front());
                if (cap_e) begin
                    if (!was_full || pop_e) mq.push_back('{idx: 8'(m_idx), c: ctrl, ne: nerr, d: data});
                    else begin
                        m_ovf = 1;
                        if (m_drop < 255) m_drop++;
                    end
                    m_idx = (m_idx + 1) % 256;
                end
                m_prev = od;
                if (TO_EN) begin
                    if (start) begin
                        m_active = 1; m_elapsed = 0; m_to = 0;
                    end else if (m_active) begin
                        m_elapsed++;
                        if (cap_e) m_active = 0;
                        else if (m_elapsed == TMO) begin
                            m_active = 0; m_to = 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                automatic ent_t h = '{idx: '0, c: '0, ne: '0, d: '0};
                if (mq.size() > 0) h = mq[0];
                check("valid",    32'(res_valid),   32'(mq.size() > 0));
                check("data",     res_data,         h.d);
                check("num_err",  32'(res_num_err), 32'(h.ne));
                check("ctrl",     32'(res_ctrl),    32'(h.c));
                check("index",    32'(res_index),   32'(h.idx));
                check("overflow", 32'(overflow),    32'(m_ovf));
                check("drop_cnt", 32'(drop_cnt),    32'(m_drop));
                check("timeout",  32'(timeout),     32'(m_to));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic capture(input logic [1:0] c, input logic [31:0] d, input logic [1:0] ne);
        ctrl = c; data = d; nerr = ne; od = 1'b1;
        tick();
        od = 1'b0;
        tick();
    endtask

    task automatic pop_n(input int n);
        ready = 1'b1;
        tick(n);
        ready = 1'b0;
    endtask

    initial begin
        tick(2);
        check("rst_valid",    32'(res_valid), 0);
        check("rst_drop",     32'(drop_cnt),  0);
        check("rst_timeout",  32'(timeout),   0);
        rst = 1'b0;

        // Single operation with done held high three cycles.
        check("single_pre_valid", 32'(res_valid), 0);
        ctrl = 2'd1; data = 32'hA5A5_0001; nerr = 2'd1; od = 1'b1;
        tick();
        check("single_valid", 32'(res_valid),   1);
        check("single_index", 32'(res_index),   0);
        check("single_data",  res_data,         32'hA5A5_0001);
        check("single_ctrl",  32'(res_ctrl),    1);
        check("single_nerr",  32'(res_num_err), 1);
        tick(2);
        od = 1'b0;
        tick();
        pop_n(1);
        check("single_one_entry", 32'(res_valid), 0);

        // Ten captures with no consumer: two drops.
        do_reset();
        for (int i = 0; i < 10; i++) capture(2'(i % 4), 32'h1000_0000 + 32'(i), 2'((i + 1) % 4));
        check("ovf_drop",  32'(drop_cnt),  2);
        check("ovf_flag",  32'(overflow),  1);
        check("ovf_head",  32'(res_index), 0);
        pop_n(8);
        check("ovf_drained", 32'(res_valid), 0);
        capture(2'd2, 32'h0000_00AA, 2'd3);
        check("ovf_next_index", 32'(res_index), 10);
        pop_n(1);

        // Reset mid-wait with three entries queued.
        for (int i = 0; i < 3; i++) capture(2'd0, 32'h2000_0000 + 32'(i), 2'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_valid",   32'(res_valid), 0);
        check("arst_timeout", 32'(timeout),   0);
        check("arst_drop",    32'(drop_cnt),  0);
        check("arst_ovf",     32'(overflow),  0);
        tick();
        rst = 1'b0;
        capture(2'd3, 32'h3000_0000, 2'd2);
        check("arst_next_index", 32'(res_index), 0);
        pop_n(1);

        // Full FIFO with capture and pop in the same cycle.
        do_reset();
        for (int i = 0; i < 8; i++) capture(2'd1, 32'h4000_0000 + 32'(i), 2'd0);
        check("full_drop0", 32'(drop_cnt), 0);
        ctrl = 2'd2; data = 32'hBEEF_0008; nerr = 2'd1; od = 1'b1; ready = 1'b1;
        tick();
        od = 1'b0; ready = 1'b0;
        check("full_nodrop", 32'(drop_cnt),  0);
        check("full_noovf",  32'(overflow),  0);
        check("full_head",   32'(res_index), 1);
        pop_n(7);
        check("full_tail_index", 32'(res_index), 8);
        check("full_tail_data",  res_data,       32'hBEEF_0008);
        pop_n(1);
        check("full_empty", 32'(res_valid), 0);

        // Watchdog: expiry, restart clear, done in cycle 2 and 1, start beating capture.
        ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("tmo_c1", 32'(timeout), 0);
        tick();
        check("tmo_c2", 32'(timeout), 32'(TO_EN));
        tick(2);
        check("tmo_sticky", 32'(timeout), 32'(TO_EN));
        start = 1'b1; tick(); start = 1'b0;
        check("tmo_cleared", 32'(timeout), 0);
        tick();
        od = 1'b1; tick(); od = 1'b0;
        tick(3);
        check("tmo_done_c2", 32'(timeout), 0);
        start = 1'b1; tick(); start = 1'b0;
        od = 1'b1; tick(); od = 1'b0;
        tick(3);
        check("tmo_done_c1", 32'(timeout), 0);
        start = 1'b1; od = 1'b1; tick(); start = 1'b0; od = 1'b0;
        tick();
        check("tmo_startwins_c1", 32'(timeout), 0);
        tick();
        check("tmo_startwins_c2", 32'(timeout), 32'(TO_EN));
        ready = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
